// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, data width and baud-divider computation.
// Used by the transmitter and by the receiver that will share this package.
package uart_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_START  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
  localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
  localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;

  // Integer-truncated clock cycles per line bit.
  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                    input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Per-bit cycle counter: o_bit_done flags the last cycle of a bit period.
// Wraps to zero on bit_done so consecutive bits in one state stay aligned.
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_bit_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_bit_done = i_enable && (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear || o_bit_done) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with a one-byte holding register so frames stream back to back.
// Frame: start, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned PARITY_EN = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              tx_busy
);

  localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);

  logic [STATE_W-1:0] r_state, w_state_d;
  logic [DATA_W-1:0]  r_hold, r_shift, w_shift_d;
  logic [2:0]         r_bit_idx, w_bit_idx_d;
  logic               r_hold_full, r_parity, r_tx, w_tx_d;
  logic               w_accept, w_load, w_bit_done, w_clear, w_enable;

  assign tx_ready = !r_hold_full;
  assign w_accept = tx_valid && !r_hold_full;
  assign tx       = r_tx;
  assign tx_busy  = (r_state != ST_IDLE);
  assign w_enable = (r_state != ST_IDLE);
  assign w_clear  = (r_state == ST_IDLE) || (w_state_d != r_state);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_enable  (w_enable),
    .o_bit_done(w_bit_done)
  );

  always_comb begin
    w_state_d   = r_state;
    w_shift_d   = r_shift;
    w_bit_idx_d = r_bit_idx;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_hold_full) begin
          w_load    = 1'b1;
          w_state_d = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_done) begin
          w_state_d   = ST_DATA;
          w_bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (w_bit_done) begin
          if (r_bit_idx == 3'(DATA_W - 1)) begin
            w_bit_idx_d = '0;
            w_state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_idx_d = r_bit_idx + 3'd1;
            w_shift_d   = r_shift >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_done) begin
          w_state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_bit_done) begin
          // r_bit_idx counts stop bits here; chain straight into the next frame if one waits.
          if (r_bit_idx == 3'(STOP_BITS - 1)) begin
            w_bit_idx_d = '0;
            if (r_hold_full) begin
              w_load    = 1'b1;
              w_state_d = ST_START;
            end else begin
              w_state_d = ST_IDLE;
            end
          end else begin
            w_bit_idx_d = r_bit_idx + 3'd1;
          end
        end
      end
      default: begin
        w_state_d   = ST_IDLE;
        w_bit_idx_d = '0;
      end
    endcase
    if (w_load) begin
      w_shift_d = r_hold;
    end
    case (w_state_d)
      ST_START:  w_tx_d = 1'b0;
      ST_DATA:   w_tx_d = w_shift_d[0];
      ST_PARITY: w_tx_d = r_parity;
      default:   w_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_tx        <= 1'b1;
      r_parity    <= 1'b0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_shift   <= w_shift_d;
      r_bit_idx <= w_bit_idx_d;
      r_tx      <= w_tx_d;
      if (w_load) begin
        r_parity <= ^r_hold;
      end
      if (w_accept) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: three instances (default, even parity, two stop bits),
// per-instance serial monitors decode frames and check them against queued expectations.
module tb_uart_tx;

  localparam int CPB = 434;

  logic       clk = 1'b0;
  int         cyc = 0;
  logic [2:0] rst_v;
  logic [2:0] vld;
  logic [7:0] dat [3];
  wire  [2:0] w_rdy;
  wire  [2:0] w_tx;
  wire  [2:0] w_busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [8:0] sb0[$];
  logic [8:0] sb1[$];
  logic [8:0] sb2[$];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx u_dut0 (
    .clk(clk), .rst(rst_v[0]), .tx_data(dat[0]), .tx_valid(vld[0]),
    .tx_ready(w_rdy[0]), .tx(w_tx[0]), .tx_busy(w_busy[0])
  );

  uart_tx #(.PARITY_EN(1)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .tx_data(dat[1]), .tx_valid(vld[1]),
    .tx_ready(w_rdy[1]), .tx(w_tx[1]), .tx_busy(w_busy[1])
  );

  uart_tx #(.STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst_v[2]), .tx_data(dat[2]), .tx_valid(vld[2]),
    .tx_ready(w_rdy[2]), .tx(w_tx[2]), .tx_busy(w_busy[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_push(input int id, input logic [8:0] v);
    case (id)
      0:       sb0.push_back(v);
      1:       sb1.push_back(v);
      default: sb2.push_back(v);
    endcase
  endtask

  task automatic sb_pop(input int id, output logic [8:0] v, output bit ok);
    ok = 1'b0;
    v  = '0;
    case (id)
      0:       if (sb0.size() > 0) begin v = sb0.pop_front(); ok = 1'b1; end
      1:       if (sb1.size() > 0) begin v = sb1.pop_front(); ok = 1'b1; end
      default: if (sb2.size() > 0) begin v = sb2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Present a byte, hold valid until accepted, queue the expected frame.
  task automatic send(input int id, input logic [7:0] b, input logic par, output int acc);
    int waited;
    waited = 0;
    @(negedge clk);
    vld[id] = 1'b1;
    dat[id] = b;
    while (w_rdy[id] !== 1'b1 && waited < 20000) begin
      @(negedge clk);
      waited++;
    end
    if (w_rdy[id] !== 1'b1) begin
      chk("accept_timeout", 32'(w_rdy[id]), 32'd1);
      vld[id] = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    sb_push(id, {par, b});
    @(posedge clk);
    #1;
    vld[id] = 1'b0;
  endtask

  // Compare the line cycle by cycle against a bit pattern of n bit periods from start.
  task automatic check_wave(input int id, input logic [23:0] bits, input int n, input int start,
                            input string name);
    int errs;
    int idx;
    errs = 0;
    @(negedge clk);
    while (cyc < start) @(negedge clk);
    while (cyc < start + n * CPB) begin
      idx = (cyc - start) / CPB;
      if (w_tx[id] !== bits[idx]) errs++;
      if (vld[id] == 1'b0) dat[id] = 8'($urandom);
      @(negedge clk);
    end
    chk(name, 32'(errs), 32'd0);
  endtask

  task automatic wait_idle(input int id, input int bound, output int at);
    int n;
    n = 0;
    while (w_busy[id] !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    at = (w_busy[id] === 1'b0) ? cyc : -1;
  endtask

  task automatic wait_n(input int id, input int n, inout bit ab);
    for (int i = 0; i < n && !ab; i++) begin
      @(negedge clk);
      if (rst_v[id]) ab = 1'b1;
    end
  endtask

  // Mid-bit sampling receiver; frames cut short by reset are dropped.
  task automatic monitor(input int id);
    logic [7:0] b;
    logic [8:0] e;
    logic       p;
    bit         ab;
    bit         frm_ok;
    bit         got;
    int         nstop;
    nstop = (id == 2) ? 2 : 1;
    forever begin
      @(negedge clk);
      if (w_tx[id] === 1'b0 && !rst_v[id]) begin
        ab     = 1'b0;
        frm_ok = 1'b1;
        b      = '0;
        p      = 1'b0;
        wait_n(id, CPB / 2, ab);
        if (w_tx[id] !== 1'b0) frm_ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          wait_n(id, CPB, ab);
          b[i] = w_tx[id];
        end
        if (id == 1) begin
          wait_n(id, CPB, ab);
          p = w_tx[id];
        end
        for (int s = 0; s < nstop; s++) begin
          wait_n(id, CPB, ab);
          if (w_tx[id] !== 1'b1) frm_ok = 1'b0;
        end
        wait_n(id, CPB - CPB / 2 - 1, ab);
        if (!ab) begin
          sb_pop(id, e, got);
          chk($sformatf("frame_expected[%0d]", id), 32'(got), 32'd1);
          if (got) begin
            chk($sformatf("data[%0d]", id), 32'(b), 32'(e[7:0]));
            chk($sformatf("framing[%0d]", id), 32'(frm_ok), 32'd1);
            if (id == 1) chk("parity[1]", 32'(p), 32'(e[8]));
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  initial begin
    int a1, a2, a3, t, quiet;
    vld    = '0;
    dat[0] = '0;
    dat[1] = '0;
    dat[2] = '0;
    rst_v  = '0;
    #1 rst_v = 3'b111;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(w_tx[0]), 32'd1);
    chk("rst_busy", 32'(w_busy[0]), 32'd0);
    chk("rst_ready", 32'(w_rdy[0]), 32'd1);
    @(posedge clk);
    #1 rst_v = '0;

    // 0x5B right after reset release; start bit one cycle after acceptance.
    send(0, 8'h5B, 1'b0, a1);
    @(negedge clk);
    chk("acc_tx_still_high", 32'(w_tx[0]), 32'd1);
    chk("acc_ready_low", 32'(w_rdy[0]), 32'd0);
    chk("acc_busy_low", 32'(w_busy[0]), 32'd0);
    @(negedge clk);
    chk("start_tx_low", 32'(w_tx[0]), 32'd0);
    chk("start_busy", 32'(w_busy[0]), 32'd1);
    chk("start_ready", 32'(w_rdy[0]), 32'd1);
    check_wave(0, 24'b1010110110, 10, a1 + 1, "wave_5b");
    wait_idle(0, 20000, t);
    chk("idle_5b", 32'(t), 32'(a1 + 1 + 10 * CPB));

    // Back-to-back 0x00, 0xFF: ready low one cycle, no gap between frames.
    send(0, 8'h00, 1'b0, a1);
    send(0, 8'hFF, 1'b0, a2);
    chk("b2b_accept_gap", 32'(a2 - a1), 32'd2);
    check_wave(0, 24'b1111_1111_1010_0000_0000, 20, a1 + 1, "wave_b2b");
    wait_idle(0, 20000, t);
    chk("idle_b2b", 32'(t), 32'(a1 + 1 + 20 * CPB));

    // Third byte waits on a full holding register for thousands of cycles.
    send(0, 8'h3C, 1'b0, a1);
    send(0, 8'h96, 1'b0, a2);
    send(0, 8'hC3, 1'b0, a3);
    chk("hold_accept_cycle", 32'(a3), 32'(a1 + 2 + 10 * CPB));
    @(negedge clk);
    wait_idle(0, 40000, t);
    chk("idle_hold", 32'(t), 32'(a1 + 1 + 30 * CPB));

    // Reset in the middle of data bit 3 of 0x55 aborts the frame for good.
    send(0, 8'h55, 1'b0, a1);
    while (cyc < a1 + 1 + 4 * CPB + CPB / 2) @(negedge clk);
    chk("pre_rst_bit3", 32'(w_tx[0]), 32'd0);
    rst_v[0] = 1'b1;
    #1;
    chk("mid_rst_tx", 32'(w_tx[0]), 32'd1);
    chk("mid_rst_busy", 32'(w_busy[0]), 32'd0);
    chk("mid_rst_ready", 32'(w_rdy[0]), 32'd1);
    sb0.delete();
    repeat (3) @(negedge clk);
    rst_v[0] = 1'b0;
    quiet = 0;
    repeat (6000) begin
      @(negedge clk);
      if (w_tx[0] !== 1'b1 || w_busy[0] !== 1'b0) quiet++;
    end
    chk("post_rst_quiet", 32'(quiet), 32'd0);

    // Even parity: 0x07 -> 1, 0x03 -> 0; 11-bit frames.
    send(1, 8'h07, 1'b1, a1);
    send(1, 8'h03, 1'b0, a2);
    check_wave(1, 24'b0110_0000_1110, 12, a1 + 1, "wave_par_07");
    wait_idle(1, 20000, t);
    chk("idle_par", 32'(t), 32'(a1 + 1 + 22 * CPB));

    // Two stop bits: 868 high cycles before the next start bit.
    send(2, 8'hA5, 1'b0, a1);
    send(2, 8'hA5, 1'b0, a2);
    check_wave(2, 24'b0111_0100_1010, 12, a1 + 1, "wave_stop2");
    wait_idle(2, 20000, t);
    chk("idle_stop2", 32'(t), 32'(a1 + 1 + 22 * CPB));

    repeat (10) @(negedge clk);
    chk("sb0_drained", 32'(sb0.size()), 32'd0);
    chk("sb1_drained", 32'(sb1.size()), 32'd0);
    chk("sb2_drained", 32'(sb2.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
